// File: rtl/trap_sequencer.sv
// Trap/return sequencer: arbitrates exceptions, interrupts and mret, then walks
// each accepted event through drain, CSR pulse, acknowledge wait and fetch redirect.
module trap_sequencer #(
  parameter int NUM_IRQ      = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               exc_valid_i,
  input  logic [31:0]        exc_cause_i,
  input  logic [31:0]        exc_pc_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_en_i,
  input  logic               mie_i,
  input  logic [31:0]        retire_pc_i,
  input  logic               mret_req_i,
  input  logic               trap_taken_i,
  input  logic [31:0]        trap_pc_i,
  output logic               csr_exception_o,
  output logic [31:0]        csr_epc_o,
  output logic [31:0]        csr_cause_o,
  output logic               csr_mret_o,
  output logic               stall_o,
  output logic               pipe_flush_o,
  output logic               redirect_valid_o,
  output logic [31:0]        redirect_pc_o,
  output logic               busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_TRAP,
    S_MRET,
    S_WAIT,
    S_REDIRECT
  } state_t;

  localparam logic [3:0] LP_LAST = 4'(FLUSH_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_kind_mret;
  logic        r_busy;
  logic        r_flush;
  logic        r_csr_exception;
  logic        r_csr_mret;
  logic        r_redirect_valid;
  logic [31:0] r_epc;
  logic [31:0] r_cause;
  logic [31:0] r_redirect_pc;

  logic [NUM_IRQ-1:0] w_irq_pend;
  logic               w_irq_take;
  logic [30:0]        w_irq_idx;
  logic               w_accept;

  // Lowest set index wins: scanning downward leaves the smallest index last.
  function automatic logic [30:0] f_lowest(input logic [NUM_IRQ-1:0] v);
    f_lowest = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (v[i]) f_lowest = 31'(i);
    end
  endfunction

  assign w_irq_pend = irq_i & irq_en_i;
  assign w_irq_take = mie_i && (|w_irq_pend);
  assign w_irq_idx  = f_lowest(w_irq_pend);
  assign w_accept   = exc_valid_i || w_irq_take || mret_req_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state          <= S_IDLE;
      r_cnt            <= '0;
      r_kind_mret      <= 1'b0;
      r_busy           <= 1'b0;
      r_flush          <= 1'b0;
      r_csr_exception  <= 1'b0;
      r_csr_mret       <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_epc            <= '0;
      r_cause          <= '0;
      r_redirect_pc    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (exc_valid_i) begin
            r_cause     <= exc_cause_i;
            r_epc       <= exc_pc_i;
            r_kind_mret <= 1'b0;
          end else if (w_irq_take) begin
            r_cause     <= {1'b1, w_irq_idx};
            r_epc       <= retire_pc_i;
            r_kind_mret <= 1'b0;
          end else if (mret_req_i) begin
            r_kind_mret <= 1'b1;
          end
          if (w_accept) begin
            r_state <= S_DRAIN;
            r_busy  <= 1'b1;
            r_flush <= 1'b1;
            r_cnt   <= '0;
          end
        end
        S_DRAIN: begin
          if (r_cnt == LP_LAST) begin
            r_flush <= 1'b0;
            if (r_kind_mret) begin
              r_state    <= S_MRET;
              r_csr_mret <= 1'b1;
            end else begin
              r_state         <= S_TRAP;
              r_csr_exception <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        // An acknowledge in the pulse cycle itself skips WAIT entirely.
        S_TRAP, S_MRET: begin
          r_csr_exception <= 1'b0;
          r_csr_mret      <= 1'b0;
          if (trap_taken_i) begin
            r_redirect_pc    <= trap_pc_i;
            r_redirect_valid <= 1'b1;
            r_state          <= S_REDIRECT;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (trap_taken_i) begin
            r_redirect_pc    <= trap_pc_i;
            r_redirect_valid <= 1'b1;
            r_state          <= S_REDIRECT;
          end
        end
        S_REDIRECT: begin
          r_redirect_valid <= 1'b0;
          r_busy           <= 1'b0;
          r_state          <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_flush <= 1'b0;
        end
      endcase
    end
  end

  assign csr_exception_o  = r_csr_exception;
  assign csr_mret_o       = r_csr_mret;
  assign csr_epc_o        = r_epc;
  assign csr_cause_o      = r_cause;
  assign stall_o          = r_busy;
  assign busy_o           = r_busy;
  assign pipe_flush_o     = r_flush;
  assign redirect_valid_o = r_redirect_valid;
  assign redirect_pc_o    = r_redirect_pc;

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Trap and return sequencer in front of `csr_unit`. It arbitrates synchronous pipeline exceptions, level-sensitive interrupt lines and `mret` requests, then runs each accepted event through a fixed sequence:

1. stall and flush the pipeline;
2. pulse the CSR unit's `exception`/`mret` inputs;
3. wait for the CSR acknowledge;
4. issue a one-cycle PC redirect to fetch.

Only one event is in flight at a time.

## Interface
Parameters:
- `NUM_IRQ`, default 3. Number of interrupt lines; index 0 has the highest priority.
- `FLUSH_CYCLES`, default 2. Drain cycles spent in DRAIN; legal range 1-15.

Ports:
- `clk_i`  in  1  single clock; all state changes on the rising edge.
- `rst_i`  in  1  reset, asynchronous and active-high.
- `exc_valid_i`  in  1  synchronous exception from the pipeline.
- `exc_cause_i`  in  32  exception cause code.
- `exc_pc_i`  in  32  PC of the faulting instruction.
- `irq_i`  in  NUM_IRQ  interrupt lines; level-sensitive and held by the source until serviced.
- `irq_en_i`  in  NUM_IRQ  per-source interrupt enables.
- `mie_i`  in  1  global interrupt enable, from csr_unit `mie_o`.
- `retire_pc_i`  in  32  PC of the next instruction to commit; used as the EPC for interrupts.
- `mret_req_i`  in  1  `mret` decoded at commit.
- `trap_taken_i`  in  1  CSR acknowledge for either a trap or an `mret`.
- `trap_pc_i`  in  32  target from the CSR unit: mtvec after a trap, mepc after `mret`.
- `csr_exception_o`  out  1  one-cycle pulse to csr_unit `exception_i`.
- `csr_epc_o`  out  32  latched EPC.
- `csr_cause_o`  out  32  latched cause.
- `csr_mret_o`  out  1  one-cycle pulse to csr_unit `mret_i`.
- `stall_o`  out  1  pipeline stall.
- `pipe_flush_o`  out  1  pipeline flush.
- `redirect_valid_o`  out  1  one-cycle fetch redirect strobe.
- `redirect_pc_o`  out  32  redirect target.
- `busy_o`  out  1  high while the sequencer is not in IDLE.

## Operation
States are IDLE, DRAIN, TRAP, MRET, WAIT and REDIRECT.

**IDLE.** Events are sampled here only. Priority, highest first:
- `exc_valid_i`: latch `exc_cause_i` and `exc_pc_i`.
- Interrupt: taken when `mie_i=1` and `(irq_i & irq_en_i)` is nonzero. Select the lowest set index `k`. Latch cause `{1'b1, 31'(k)}` and EPC = `retire_pc_i`.
- `mret_req_i`: set the `kind=MRET` flag. Cause and EPC stay unchanged.

Any accepted event moves to DRAIN.

**DRAIN.**
- Hold `pipe_flush_o=1` for exactly `FLUSH_CYCLES` cycles, counted by a 4-bit counter.
- Exit to TRAP, or to MRET when the flag is set.

**TRAP / MRET.**
- Pulse the matching CSR output for exactly one cycle.
- If `trap_taken_i` is already high in that cycle, latch `trap_pc_i` and go straight to REDIRECT. Otherwise go to WAIT.

**WAIT.**
- Stay until `trap_taken_i=1`, then latch `trap_pc_i` into `redirect_pc_o` and go to REDIRECT.
- No timeout.

**REDIRECT.** Assert `redirect_valid_o=1` for one cycle, then return to IDLE.

Other rules:
- `stall_o` = `busy_o` = (state != IDLE).
- `csr_epc_o` and `csr_cause_o` hold their latched values until the next accepted event.
- Events arriving while busy are ignored; level-held interrupts are re-evaluated on return to IDLE. `trap_taken_i` outside TRAP, MRET and WAIT is ignored.
- Simultaneous events: an exception beats an interrupt, which beats `mret`. A dropped `mret` is lost, because the pipeline is flushed.
- Interrupts are masked while `mie_i=0`. Exceptions and `mret` are never masked.

## Timing
- Reset values (asynchronous): state IDLE, counter 0, and every output 0, including `csr_epc_o`, `csr_cause_o` and `redirect_pc_o`.
- Assertion of `rst_i` mid-sequence aborts immediately: no CSR pulse and no redirect.
- Event sampled at edge 0: DRAIN occupies cycles 1 to F, where F = `FLUSH_CYCLES`.
- The CSR pulse is in cycle F+1.
- Earliest redirect is cycle F+2, when the acknowledge arrives in the same cycle as the pulse.
- IDLE is re-entered at cycle F+3, and a new event can be accepted in that cycle. Minimum event-to-event spacing is therefore F+3 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
With F=2:
- **Exception:** `exc_valid_i=1`, cause=11, pc=0x200 at cycle 0; `trap_taken_i` arrives with `trap_pc_i`=0x100 in cycle 3 -> `pipe_flush_o` high in cycles 1-2; `csr_exception_o` high in cycle 3 with epc=0x200 and cause=11; `redirect_valid_o` high in cycle 4 with pc=0x100.
- **Interrupt priority:** `irq_i`=3'b110, `irq_en_i`=3'b111, `mie_i`=1, `retire_pc_i`=0x340 -> cause=0x8000_0001, epc=0x340. Repeat with `mie_i`=0 -> no event, `busy_o` stays 0.
- **Mret:** `mret_req_i` at cycle 0; acknowledge delayed to cycle 6 with `trap_pc_i`=0x204 -> `csr_mret_o` high only in cycle 3; WAIT holds `stall_o`=1 through cycle 6; redirect in cycle 7 to 0x204.
- **Collision:** `exc_valid_i`, `irq_i[0]` and `mret_req_i` all high in the same cycle -> exception cause/pc latched, no `csr_mret_o` pulse. The interrupt is serviced in the next sequence once IDLE is re-entered.
- **Busy ignore:** `exc_valid_i` pulsed during DRAIN -> ignored; cause/pc unchanged.
- **Reset mid-op:** assert `rst_i` in WAIT -> all outputs 0 immediately; a later `trap_taken_i` produces no redirect.
